// File: rtl/up_bus_pkg.sv
// Shared constants for the uP-to-register-bank bridge: FSM encodings,
// transfer direction and the default soft-reset address.
package up_bus_pkg;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_ADDR_ACK  = 3'd1;
   localparam logic [2:0] S_DATA_WAIT = 3'd2;
   localparam logic [2:0] S_DATA_ACK  = 3'd3;
   localparam logic [2:0] S_COMMIT    = 3'd4;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   localparam logic [7:0] DEF_SOFT_RESET_ADDR = 8'hFF;

   // Number of uP beats needed to move one register word.
   function automatic int unsigned beats(input int unsigned reg_w, input int unsigned up_w);
      return reg_w / up_w;
   endfunction

endpackage

// File: rtl/up_hs_sync.sv
// Multi-stage synchroniser bringing the asynchronous uP strobe and direction
// into the clk domain.
module up_hs_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic hs1_a,
   input  logic rw_a,
   output logic hs1_s,
   output logic rw_s
);

   logic [STAGES-1:0] hs1_sr;
   logic [STAGES-1:0] rw_sr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hs1_sr <= '0;
         rw_sr  <= '0;
      end else begin
         hs1_sr[0] <= hs1_a;
         rw_sr[0]  <= rw_a;
         for (int i = 1; i < int'(STAGES); i++) begin
            hs1_sr[i] <= hs1_sr[i-1];
            rw_sr[i]  <= rw_sr[i-1];
         end
      end
   end

   assign hs1_s = hs1_sr[STAGES-1];
   assign rw_s  = rw_sr[STAGES-1];

endmodule

// File: rtl/up_bus_bridge.sv
// 4-phase handshake bridge from a narrow uP bus to a wide internal register
// bus: one address beat then REG_W/UP_W data beats, LSB beat first.
module up_bus_bridge
   import up_bus_pkg::*;
#(
   parameter int unsigned       UP_W              = 8,
   parameter int unsigned       REG_W             = 32,
   parameter int unsigned       ADDR_W            = 8,
   parameter int unsigned       SYNC_STAGES       = 2,
   parameter int unsigned       TIMEOUT_CYCLES    = 1024,
   parameter logic [ADDR_W-1:0] SOFT_RESET_ADDR   = ADDR_W'(DEF_SOFT_RESET_ADDR),
   parameter int unsigned       SOFT_RESET_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [UP_W-1:0]   up_data_in,
   output logic [UP_W-1:0]   up_data_out,
   output logic              up_data_oe,
   input  logic              up_rw,
   input  logic              up_hs1,
   output logic              up_hs2,
   output logic [ADDR_W-1:0] reg_address,
   output logic [REG_W-1:0]  reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [REG_W-1:0]  reg_rdata,
   output logic              soft_reset,
   output logic              busy,
   output logic              timeout_err
);

   localparam int unsigned BEATS  = beats(REG_W, UP_W);
   localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned SR_W   = $clog2(SOFT_RESET_CYCLES + 1);

   logic                        hs1_s, rw_s;
   logic [2:0]                  state, state_nxt;
   logic                        armed, dir, dir_nxt;
   logic [BEAT_W-1:0]           beat_cnt, beat_nxt;
   logic [TO_W-1:0]             phase_cnt;
   logic [SR_W-1:0]             sr_cnt;
   logic                        rd_pending;
   logic [BEATS-1:0][UP_W-1:0]  rd_hold, wdata_q;
   logic                        start, load, timeout, last_beat, oe_nxt;
   logic                        commit_we, commit_sr;

   up_hs_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .hs1_a (up_hs1),
      .rw_a  (up_rw),
      .hs1_s (hs1_s),
      .rw_s  (rw_s)
   );

   assign reg_wdata = wdata_q;

   // Next state plus the single-cycle events that drive the datapath.
   always_comb begin
      state_nxt = state;
      beat_nxt  = beat_cnt;
      dir_nxt   = dir;
      start     = 1'b0;
      load      = 1'b0;
      timeout   = 1'b0;
      last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
      case (state)
         S_IDLE: begin
            if (armed && hs1_s) begin
               start     = 1'b1;
               state_nxt = S_ADDR_ACK;
               beat_nxt  = '0;
               dir_nxt   = rw_s;
            end
         end
         S_ADDR_ACK: begin
            if (!hs1_s) state_nxt = S_DATA_WAIT;
         end
         S_DATA_WAIT: begin
            if (hs1_s) begin
               state_nxt = S_DATA_ACK;
               load      = (dir == RW_WRITE);
            end
         end
         S_DATA_ACK: begin
            if (!hs1_s) begin
               if (!last_beat) begin
                  beat_nxt  = beat_cnt + BEAT_W'(1);
                  state_nxt = S_DATA_WAIT;
               end else if (dir == RW_WRITE) begin
                  state_nxt = S_COMMIT;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         S_COMMIT: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
      // A stalled phase overrides any normal transition.
      if (state != S_IDLE && state != S_COMMIT &&
          phase_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
         timeout   = 1'b1;
         state_nxt = S_IDLE;
         load      = 1'b0;
         beat_nxt  = beat_cnt;
      end
      oe_nxt    = (dir_nxt == RW_READ) &&
                  (state_nxt == S_DATA_WAIT || state_nxt == S_DATA_ACK);
      commit_we = (state_nxt == S_COMMIT) && (reg_address != SOFT_RESET_ADDR);
      commit_sr = (state_nxt == S_COMMIT) && (reg_address == SOFT_RESET_ADDR) &&
                  wdata_q[0][0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Registered outputs and transaction datapath.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         armed       <= 1'b0;
         dir         <= 1'b0;
         beat_cnt    <= '0;
         phase_cnt   <= '0;
         sr_cnt      <= '0;
         rd_pending  <= 1'b0;
         rd_hold     <= '0;
         wdata_q     <= '0;
         reg_address <= '0;
         reg_we      <= 1'b0;
         reg_re      <= 1'b0;
         up_hs2      <= 1'b0;
         up_data_oe  <= 1'b0;
         up_data_out <= '0;
         soft_reset  <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (start)                       armed <= 1'b0;
         else if (state == S_IDLE && !hs1_s) armed <= 1'b1;
         dir      <= dir_nxt;
         beat_cnt <= beat_nxt;
         if (state_nxt != state)                       phase_cnt <= '0;
         else if (state != S_IDLE && state != S_COMMIT) phase_cnt <= phase_cnt + TO_W'(1);
         if (start) reg_address <= up_data_in[ADDR_W-1:0];
         if (start)        timeout_err <= 1'b0;
         else if (timeout) timeout_err <= 1'b1;
         reg_re     <= start && (rw_s == RW_READ);
         rd_pending <= reg_re;
         if (rd_pending) rd_hold <= reg_rdata;
         if (load) wdata_q[beat_cnt] <= up_data_in;
         up_hs2      <= (state_nxt == S_ADDR_ACK) || (state_nxt == S_DATA_ACK);
         up_data_oe  <= oe_nxt;
         up_data_out <= oe_nxt ? rd_hold[beat_nxt] : '0;
         reg_we      <= commit_we;
         busy        <= (state_nxt != S_IDLE);
         // Pulse stretcher: soft_reset stays high for SOFT_RESET_CYCLES clocks.
         if (commit_sr) begin
            soft_reset <= 1'b1;
            sr_cnt     <= SR_W'(SOFT_RESET_CYCLES - 1);
         end else if (sr_cnt != '0) begin
            sr_cnt <= sr_cnt - SR_W'(1);
         end else begin
            soft_reset <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_up_bus_bridge.sv
// Directed bench: default 8/32 bridge plus a 16/32 variant, driven by a
// simple uP handshake model with hand-computed expectations.
module tb_up_bus_bridge;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Default-parameter instance (8-bit uP bus)
   logic [7:0]  a_din, a_dout, a_addr;
   logic        a_oe, a_rw, a_hs1, a_hs2, a_we, a_re, a_sr, a_busy, a_to;
   logic [31:0] a_wdata, a_rdata;

   // 16-bit uP bus instance
   logic [15:0] b_din, b_dout;
   logic [7:0]  b_addr;
   logic        b_oe, b_rw, b_hs1, b_hs2, b_we, b_re, b_sr, b_busy, b_to;
   logic [31:0] b_wdata, b_rdata;

   up_bus_bridge dut_a (
      .clk(clk), .reset(reset), .up_data_in(a_din), .up_data_out(a_dout),
      .up_data_oe(a_oe), .up_rw(a_rw), .up_hs1(a_hs1), .up_hs2(a_hs2),
      .reg_address(a_addr), .reg_wdata(a_wdata), .reg_we(a_we), .reg_re(a_re),
      .reg_rdata(a_rdata), .soft_reset(a_sr), .busy(a_busy), .timeout_err(a_to)
   );

   up_bus_bridge #(.UP_W(16), .REG_W(32)) dut_b (
      .clk(clk), .reset(reset), .up_data_in(b_din), .up_data_out(b_dout),
      .up_data_oe(b_oe), .up_rw(b_rw), .up_hs1(b_hs1), .up_hs2(b_hs2),
      .reg_address(b_addr), .reg_wdata(b_wdata), .reg_we(b_we), .reg_re(b_re),
      .reg_rdata(b_rdata), .soft_reset(b_sr), .busy(b_busy), .timeout_err(b_to)
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Event monitors, sampled on the inactive edge
   int a_hs2_rises = 0, a_we_cnt = 0, a_re_cnt = 0, a_sr_cycles = 0;
   int b_hs2_rises = 0, b_we_cnt = 0;
   logic [7:0]  a_we_addr = '0;
   logic [31:0] a_we_data = '0;
   logic a_hs2_q = 1'b0, b_hs2_q = 1'b0;

   always @(negedge clk) begin
      if (a_hs2 && !a_hs2_q) a_hs2_rises++;
      if (b_hs2 && !b_hs2_q) b_hs2_rises++;
      a_hs2_q = a_hs2;
      b_hs2_q = b_hs2;
      if (a_we) begin
         a_we_cnt++;
         a_we_addr = a_addr;
         a_we_data = a_wdata;
      end
      if (a_re) a_re_cnt++;
      if (a_sr) a_sr_cycles++;
      if (b_we) b_we_cnt++;
   end

   task automatic wait_a_hs2(input logic v, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (a_hs2 == v) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // One full 4-phase handshake on instance A; returns the read beat seen at hs2 rise.
   task automatic a_hs(input logic [7:0] d, input logic rw, output logic [7:0] rd);
      bit ok;
      a_din = d;
      a_rw  = rw;
      a_hs1 = 1'b1;
      wait_a_hs2(1'b1, 64, ok);
      chk("a_hs2_rise", 64'(ok), 64'd1);
      rd = a_dout;
      a_hs1 = 1'b0;
      wait_a_hs2(1'b0, 64, ok);
      chk("a_hs2_fall", 64'(ok), 64'd1);
   endtask

   task automatic a_write(input logic [7:0] addr, input logic [31:0] d);
      logic [7:0] rd;
      a_hs(addr, 1'b0, rd);
      for (int i = 0; i < 4; i++) a_hs(d[i*8 +: 8], 1'b0, rd);
      repeat (4) @(negedge clk);
   endtask

   task automatic b_hs(input logic [15:0] d, input logic rw);
      bit ok;
      b_din = d;
      b_rw  = rw;
      b_hs1 = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge clk);
         ok = b_hs2;
      end
      chk("b_hs2_rise", 64'(ok), 64'd1);
      b_hs1 = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge clk);
         ok = !b_hs2;
      end
      chk("b_hs2_fall", 64'(ok), 64'd1);
   endtask

   initial begin
      int hs0, we0, re0, sr0;
      logic [7:0] rd;
      logic [31:0] rdw;
      bit ok;

      reset = 1'b0;
      a_din = '0; a_rw = 1'b0; a_hs1 = 1'b0; a_rdata = '0;
      b_din = '0; b_rw = 1'b0; b_hs1 = 1'b0; b_rdata = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs",
          64'({a_dout, a_oe, a_hs2, a_addr, a_we, a_re, a_sr, a_busy, a_to}), 64'd0);
      chk("reset_wdata", 64'(a_wdata), 64'd0);
      reset = 1'b1;
      repeat (5) @(negedge clk);

      // Write 0x12345678 to 0x12
      hs0 = a_hs2_rises; we0 = a_we_cnt;
      a_write(8'h12, 32'h1234_5678);
      chk("wr_we_count", 64'(a_we_cnt - we0), 64'd1);
      chk("wr_addr", 64'(a_we_addr), 64'h12);
      chk("wr_data", 64'(a_we_data), 64'h1234_5678);
      chk("wr_hs2_toggles", 64'(a_hs2_rises - hs0), 64'd5);
      chk("wr_busy_done", 64'(a_busy), 64'd0);

      // Read 0xDEADBEEF from 0x05
      a_rdata = 32'hDEAD_BEEF;
      re0 = a_re_cnt; we0 = a_we_cnt;
      a_hs(8'h05, 1'b1, rd);
      rdw = '0;
      for (int i = 0; i < 4; i++) begin
         a_hs(8'h00, 1'b1, rd);
         rdw[i*8 +: 8] = rd;
      end
      chk("rd_oe_after", 64'(a_oe), 64'd0);
      chk("rd_data", 64'(rdw), 64'hDEAD_BEEF);
      chk("rd_re_count", 64'(a_re_cnt - re0), 64'd1);
      chk("rd_no_we", 64'(a_we_cnt - we0), 64'd0);
      chk("rd_addr", 64'(a_addr), 64'h05);

      // Soft reset via address 0xFF
      we0 = a_we_cnt; sr0 = a_sr_cycles;
      a_write(8'hFF, 32'h0000_0001);
      repeat (30) @(negedge clk);
      chk("sr_no_we", 64'(a_we_cnt - we0), 64'd0);
      chk("sr_pulse_len", 64'(a_sr_cycles - sr0), 64'd16);

      // Timeout with hs1 stuck high after the address beat
      a_din = 8'h40; a_rw = 1'b0; a_hs1 = 1'b1;
      wait_a_hs2(1'b1, 64, ok);
      chk("to_addr_ack", 64'(ok), 64'd1);
      wait_a_hs2(1'b0, 1200, ok);
      chk("to_hs2_drop", 64'(ok), 64'd1);
      chk("to_err_set", 64'(a_to), 64'd1);
      chk("to_busy_clear", 64'(a_busy), 64'd0);
      repeat (30) @(negedge clk);
      chk("to_no_restart", 64'({a_busy, a_hs2}), 64'd0);
      a_hs1 = 1'b0;
      repeat (5) @(negedge clk);
      a_write(8'h21, 32'hCAFE_F00D);
      chk("to_err_cleared", 64'(a_to), 64'd0);
      chk("to_recover_addr", 64'(a_we_addr), 64'h21);
      chk("to_recover_data", 64'(a_we_data), 64'hCAFE_F00D);

      // Reset in the middle of a write
      we0 = a_we_cnt;
      a_hs(8'h33, 1'b0, rd);
      a_hs(8'h11, 1'b0, rd);
      a_hs(8'h22, 1'b0, rd);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_reset_outputs",
          64'({a_dout, a_oe, a_hs2, a_addr, a_we, a_re, a_sr, a_busy, a_to}), 64'd0);
      chk("mid_reset_wdata", 64'(a_wdata), 64'd0);
      a_hs1 = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      chk("mid_reset_no_we", 64'(a_we_cnt - we0), 64'd0);
      a_write(8'h44, 32'h0BAD_F00D);
      chk("post_reset_we", 64'(a_we_cnt - we0), 64'd1);
      chk("post_reset_data", 64'({a_we_addr, a_we_data}), 64'h44_0BAD_F00D);

      // 16-bit uP bus: two data beats
      hs0 = b_hs2_rises; we0 = b_we_cnt;
      b_hs(16'h0003, 1'b0);
      b_hs(16'hBEEF, 1'b0);
      b_hs(16'hDEAD, 1'b0);
      repeat (4) @(negedge clk);
      chk("w16_we_count", 64'(b_we_cnt - we0), 64'd1);
      chk("w16_addr", 64'(b_addr), 64'h03);
      chk("w16_data", 64'(b_wdata), 64'hDEAD_BEEF);
      chk("w16_handshakes", 64'(b_hs2_rises - hs0), 64'd3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/up_bus_bridge.md
Name: up_bus_bridge

Overview:
- Parametrised successor to the 8-bit uP interface, implementing a full microcontroller-to-register-bank bridge.
- Runs a 4-phase handshake (hs1 from the uP, hs2 back to it) over an UP_W-bit data bus.
- Each transaction is one address beat followed by REG_W/UP_W data beats, LSB beat first.
- Drives the internal register bus (address, write data, write/read strobes), plus soft reset and timeout recovery.

Parameters:
- UP_W, 8: uP data bus width in bits.
- REG_W, 32: internal register width; must be an integer multiple of UP_W. BEATS = REG_W/UP_W.
- ADDR_W, 8: register address width; must be <= UP_W.
- SYNC_STAGES, 2: flip-flop stages in the up_hs1/up_rw synchroniser.
- TIMEOUT_CYCLES, 1024: clk cycles allowed for each handshake phase before abort.
- SOFT_RESET_ADDR, 8'hFF: write address that triggers soft reset instead of a register write.
- SOFT_RESET_CYCLES, 16: soft_reset pulse length in cycles.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-low.
- up_data_in, in, UP_W: uP-driven data (address or write beat).
- up_data_out, out, UP_W: read beat to the uP.
- up_data_oe, out, 1: tristate enable for up_data_out.
- up_rw, in, 1: 1 = read, 0 = write; sampled with the address beat.
- up_hs1, in, 1: uP strobe; asynchronous.
- up_hs2, out, 1: FPGA acknowledge.
- reg_address, out, ADDR_W: latched register address.
- reg_wdata, out, REG_W: assembled write data.
- reg_we, out, 1: 1-cycle write strobe.
- reg_re, out, 1: 1-cycle read strobe.
- reg_rdata, in, REG_W: read data, valid the cycle after reg_re.
- soft_reset, out, 1: active-high soft reset pulse.
- busy, out, 1: high whenever the FSM is not in S_IDLE.
- timeout_err, out, 1: sticky abort flag.

Behaviour:
- Reset (async, reset=0): all outputs 0 and state S_IDLE. Reset mid-transaction abandons the transfer; no reg_we is issued.
- up_hs1 and up_rw pass through the SYNC_STAGES synchroniser (hs1_s, rw_s). up_data_in is sampled only while hs1_s=1; the protocol guarantees the data is stable then.
- armed flag: set while hs1_s=0 in S_IDLE. A new transaction starts only when armed=1 and hs1_s=1, so an hs1 still high after an abort is ignored.
- S_IDLE -> S_ADDR_ACK on start:
  - latch reg_address = up_data_in[ADDR_W-1:0] and dir = rw_s;
  - clear timeout_err;
  - beat_cnt = 0;
  - if dir=read, pulse reg_re this cycle.
- S_ADDR_ACK: up_hs2=1. If dir=read, capture reg_rdata into rd_hold on the cycle after reg_re. When hs1_s=0: up_hs2=0 -> S_DATA_WAIT.
- S_DATA_WAIT:
  - read: up_data_oe=1, up_data_out = rd_hold[beat_cnt*UP_W +: UP_W].
  - write: up_data_oe=0.
  - On hs1_s=1 with write: load reg_wdata[beat_cnt*UP_W +: UP_W] = up_data_in. Then -> S_DATA_ACK.
- S_DATA_ACK: up_hs2=1; up_data_oe stays 1 for reads. When hs1_s=0, drop up_hs2:
  - beat_cnt < BEATS-1: beat_cnt++ -> S_DATA_WAIT.
  - last beat, write: -> S_COMMIT.
  - last beat, read: up_data_oe=0 -> S_IDLE.
- S_COMMIT, one cycle:
  - reg_address != SOFT_RESET_ADDR: reg_we=1.
  - reg_address == SOFT_RESET_ADDR and reg_wdata[0]=1: no reg_we; start soft_reset for SOFT_RESET_CYCLES cycles.
  - Then -> S_IDLE.
- A soft_reset pulse in progress does not block new transactions and does not reset this block.
- Timeout:
  - Phase counter clears on every state change and counts in every state except S_IDLE and S_COMMIT.
  - When it reaches TIMEOUT_CYCLES-1: up_hs2=0, up_data_oe=0, no strobes, timeout_err=1, -> S_IDLE.
- BEATS=1: beat_cnt is held at 0 and each transaction is exactly two handshakes.
- Minimum write transaction: reg_we fires 1 cycle after the final hs1_s fall.

Decomposition:
- Package up_bus_pkg:
  - state enum (S_IDLE, S_ADDR_ACK, S_DATA_WAIT, S_DATA_ACK, S_COMMIT);
  - RW_READ/RW_WRITE constants;
  - default SOFT_RESET_ADDR;
  - helper function beats(REG_W, UP_W).
- Sub-module up_hs_sync: parametrised SYNC_STAGES synchroniser for hs1 and rw with async active-low reset. Everything else stays in up_bus_bridge.

Test Plan:
1. Write, default params: addr 8'h12, data beats 0x78, 0x56, 0x34, 0x12 -> one reg_we pulse with reg_address=0x12, reg_wdata=32'h12345678; up_hs2 toggles 5 times.
2. Read: addr 8'h05, reg_rdata=32'hDEADBEEF -> reg_re pulses once; uP receives EF, BE, AD, DE; up_data_oe=0 after the last hs2 fall.
3. Soft reset: write addr 8'hFF, data 0x00000001 -> no reg_we; soft_reset high exactly 16 cycles.
4. Timeout: hs1 held high after the address beat for >1024 cycles -> hs2 drops, timeout_err=1, busy=0. hs1 still high does not start a new transaction; after hs1 low then high, a new address is accepted and timeout_err clears.
5. Reset mid-write: assert reset after beat 2 -> all outputs 0 immediately; no reg_we afterwards; the next full write completes normally.
6. UP_W=16, REG_W=32: write addr 0x03, beats 0xBEEF, 0xDEAD -> reg_wdata=32'hDEADBEEF after 3 handshakes.
